// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO (rclk domain): synchronises the Gray write
// pointer, issues SRAM reads and buffers the one-cycle read latency in a 2-entry queue.
module fifo_rd_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 10
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [PTR_WIDTH:0]    wptr_gray,
  output logic [PTR_WIDTH:0]    rptr_gray,
  output logic                  rcsb,
  output logic [PTR_WIDTH-1:0]  raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  empty
);

  localparam logic [PTR_WIDTH-1:0] ADDR_MASK = PTR_WIDTH'(DEPTH - 1);

  logic [PTR_WIDTH:0]    wq1;
  logic [PTR_WIDTH:0]    wq2;
  logic [PTR_WIDTH:0]    rbin;
  logic [PTR_WIDTH:0]    rbin_nxt;
  logic                  pending;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;
  logic                  issue;
  logic [2:0]            fill;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
    end
  end

  assign empty      = (rptr_gray == wq2);
  assign dout_valid = (occ != 2'd0);
  assign dout       = head;
  assign pop        = dout_valid & dout_ready;

  // Words already buffered or in flight, minus the one leaving this cycle.
  assign fill  = {1'b0, occ} + {2'b0, pending} - {2'b0, pop};
  assign issue = !empty && (fill < 3'd2);

  assign rcsb     = !issue;
  assign raddr    = rbin[PTR_WIDTH-1:0] & ADDR_MASK;
  assign rbin_nxt = rbin + {{PTR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      pending   <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        rbin      <= rbin_nxt;
        rptr_gray <= rbin_nxt ^ (rbin_nxt >> 1);
      end
    end
  end

  // A capture never meets occ == 2 without a pop: issue gating keeps occ + pending <= 2.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (pending) begin
      if (pop) begin
        if (occ == 2'd2) begin
          head <= tail;
          tail <= rdata;
        end else begin
          head <= rdata;
        end
      end else begin
        if (occ == 2'd0) head <= rdata;
        else             tail <= rdata;
        occ <= occ + 2'd1;
      end
    end else if (pop) begin
      head <= tail;
      occ  <= occ - 2'd1;
    end
  end

endmodule
